// File: rtl/ula_multiciclo.sv
// Registered MIPS ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU
// with a HI register, issued through a start/busy/done handshake.
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [0:3]       op,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic [0:WIDTH-1] result,
  output logic [0:WIDTH-1] hi,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;      // multiplicand for MUL, divisor for DIV
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem, quo;

  logic [WIDTH-1:0] ain, bin, alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]   sh_rem;
  logic [WIDTH-1:0] diff, rem_nx, quo_nx;
  logic             ge;

  assign ain = a;
  assign bin = b;

  // Single-cycle result, computed straight from the issuing operands
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = ain + bin;
        alu_ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = ain - bin;
        alu_ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  alu_res = ain & bin;
      OP_OR:   alu_res = ain | bin;
      OP_NOR:  alu_res = ~(ain | bin);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(ain) < $signed(bin)};
      default: alu_res = '0;
    endcase
  end

  // Shift-add step; the add carry lands in the top bit after the shift
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) mul_sum = mul_sum + {1'b0, opnd};
    acc_nx = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring division step
  always_comb begin
    sh_rem = {rem, quo[WIDTH-1]};
    ge     = sh_rem >= {1'b0, opnd};
    diff   = sh_rem[WIDTH-1:0] - opnd;
    rem_nx = ge ? diff : sh_rem[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
        if (op == OP_MULTU)     state_nx = MUL;
        else if (op == OP_DIVU) state_nx = DIV;
      end
      MUL, DIV: if (cnt == CW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      result   <= '0;
      hi       <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op == OP_MULTU) begin
            acc  <= {{WIDTH{1'b0}}, bin};
            opnd <= ain;
            cnt  <= CW'(WIDTH);
          end else if (op == OP_DIVU) begin
            rem  <= '0;
            quo  <= ain;
            opnd <= bin;
            cnt  <= CW'(WIDTH);
          end else begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
            done     <= 1'b1;
          end
        end
        MUL: begin
          acc <= acc_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result   <= acc_nx[WIDTH-1:0];
            hi       <= acc_nx[2*WIDTH-1:WIDTH];
            zero     <= (acc_nx[WIDTH-1:0] == '0);
            overflow <= 1'b0;
            done     <= 1'b1;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result   <= quo_nx;
            hi       <= rem_nx;
            zero     <= (quo_nx == '0);
            overflow <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
